// File: rtl/hr_init_pkg.sv
// rtl/hr_init_pkg.sv - shared state encoding and timing helpers for the HyperRAM init sequencer
package hr_init_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_POWER_UP    = 3'd1,
        ST_RST_PULSE   = 3'd2,
        ST_RST_RECOVER = 3'd3,
        ST_READY       = 3'd4
    } hr_init_state_e;

    // Rounds up so a phase is never shorter than the datasheet minimum.
    function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                                 input longint unsigned freq);
        longint unsigned cyc;
        cyc = (ns * freq + 64'd999_999_999) / 64'd1_000_000_000;
        if (cyc == 64'd0) cyc = 64'd1;
        return cyc[31:0];
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hr_sync2.sv
// rtl/hr_sync2.sv - two-flop synchroniser into the clk_hr domain
module hr_sync2 #(
    parameter int Width = 1
) (
    input  logic             clk_hr,
    input  logic             rst_hr,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [Width-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [Width-1:0] sync_q;

    always_ff @(posedge clk_hr) begin
        if (rst_hr) begin
            meta   <= '0;
            sync_q <= '0;
        end else begin
            meta   <= d;
            sync_q <= meta;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/hr_init_seq.sv
// rtl/hr_init_seq.sv - HyperRAM power-up / RESET# sequencer driven by PLL lock
module hr_init_seq
    import hr_init_pkg::*;
#(
    parameter int unsigned ClkFreqHz = 100_000_000,
    parameter int unsigned TvcsNs    = 150_000,
    parameter int unsigned TrpNs     = 200,
    parameter int unsigned TrhNs     = 200
) (
    input  logic       clk_hr,
    input  logic       rst_hr,
    input  logic       locked_i,
    input  logic       restart_i,
    output logic       hr_rst_n_o,
    output logic       init_done_o,
    output logic       lock_lost_o,
    output logic [2:0] state_o
);

    localparam int unsigned TvcsCyc = ns_to_cycles(64'(TvcsNs), 64'(ClkFreqHz));
    localparam int unsigned TrpCyc  = ns_to_cycles(64'(TrpNs), 64'(ClkFreqHz));
    localparam int unsigned TrhCyc  = ns_to_cycles(64'(TrhNs), 64'(ClkFreqHz));
    localparam int unsigned MaxCyc  = max3(TvcsCyc, TrpCyc, TrhCyc);
    localparam int          CntW    = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] TvcsLoad = CntW'(TvcsCyc - 1);
    localparam logic [CntW-1:0] TrpLoad  = CntW'(TrpCyc - 1);
    localparam logic [CntW-1:0] TrhLoad  = CntW'(TrhCyc - 1);

    hr_init_state_e  state;
    logic [CntW-1:0] cnt;
    logic            locked_s;

    hr_sync2 #(.Width(1)) u_lock_sync (
        .clk_hr (clk_hr),
        .rst_hr (rst_hr),
        .d      (locked_i),
        .q      (locked_s)
    );

    // Outputs are decoded on the transition so they change on the same edge as the state.
    always_ff @(posedge clk_hr) begin
        if (rst_hr) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            hr_rst_n_o  <= 1'b0;
            init_done_o <= 1'b0;
            lock_lost_o <= 1'b0;
        end else if (restart_i) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            hr_rst_n_o  <= 1'b0;
            init_done_o <= 1'b0;
            lock_lost_o <= 1'b0;
        end else if (!locked_s && state != ST_WAIT_LOCK) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            hr_rst_n_o  <= 1'b0;
            init_done_o <= 1'b0;
            lock_lost_o <= 1'b1;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= ST_POWER_UP;
                        cnt   <= TvcsLoad;
                    end
                end
                ST_POWER_UP: begin
                    if (cnt == '0) begin
                        state <= ST_RST_PULSE;
                        cnt   <= TrpLoad;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_RST_PULSE: begin
                    if (cnt == '0) begin
                        state      <= ST_RST_RECOVER;
                        cnt        <= TrhLoad;
                        hr_rst_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_RST_RECOVER: begin
                    if (cnt == '0) begin
                        state       <= ST_READY;
                        init_done_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_READY: begin
                    cnt <= '0;
                end
                default: begin
                    state       <= ST_WAIT_LOCK;
                    cnt         <= '0;
                    hr_rst_n_o  <= 1'b0;
                    init_done_o <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
